// File: rtl/mem_access_pkg.sv
// Shared types and widths for the memory stage and the writeback stage that consumes it.
package mem_access_pkg;

    localparam int PC_W   = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus. The memory stage is the master; the memory is the slave.
interface mem_access_if;
    import mem_access_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/mem_access_req_fsm.sv
// Request sequencer for the memory stage: owns the state, the bus request registers and,
// when MEM_TIMEOUT_EN is defined, the ack timeout counter.
//
// state | meaning
// IDLE  | ready; a load/store with ex_valid is latched and launched on the bus
// WAIT  | request held on the bus until mem_ack (or timeout)
// DONE  | one dead cycle while writeback consumes the result
module mem_req_fsm
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              isStore,
    input  logic              isLoad,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    mem_access_if.master      bus,
    output mem_state_t        state,
    output logic              loadOp,
    output logic              xferDone,
    output logic              xferFail,
    output logic              memErr
);

    if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
        $error("mem_req_fsm: TIMEOUT_CYCLES must be at least 1");
    end

    assign xferDone = (state == WAIT) && (bus.mem_ack || xferFail);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            loadOp        <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= WAIT;
                        loadOp        <= isLoad;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= isStore;
                        bus.mem_addr  <= addr;
                        bus.mem_wdata <= wdata;
                    end
                end
                WAIT: begin
                    if (xferDone) begin
                        state       <= DONE;
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] waitCnt;

    // An ack in the final allowed cycle still wins over the timeout.
    assign xferFail = (state == WAIT) && !bus.mem_ack && (waitCnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt <= '0;
            memErr  <= 1'b0;
        end else begin
            memErr <= xferFail;
            if (state != WAIT) begin
                waitCnt <= '0;
            end else if (waitCnt != CNT_MAX) begin
                waitCnt <= waitCnt + CNT_W'(1);
            end
        end
    end
`else
    assign xferFail = 1'b0;
    assign memErr   = 1'b0;
`endif

endmodule

// File: rtl/mem_access.sv
// Pipeline memory stage: launches loads/stores on the data-memory bus, stalls upstream until the
// response, and registers PC/ALU result/load data for writeback. Optional ack timeout: MEM_TIMEOUT_EN.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [PC_W-1:0]   PC,
    input  logic [DATA_W-1:0] ALURes,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic              stall,
    mem_access_if.master      bus,
    output logic              wb_valid,
    output logic [PC_W-1:0]   PCOut,
    output logic [DATA_W-1:0] ALUResOut,
    output logic [DATA_W-1:0] MemReadDataOut,
    output logic              MemReadOut,
    output logic              mem_err
);

    mem_state_t fsmState;
    logic       memOp;
    logic       accept;
    logic       loadOp;
    logic       xferDone;
    logic       xferFail;

    assign memOp  = MemRead || MemWrite;
    assign accept = (fsmState == IDLE) && ex_valid;

    // A load/store presented in IDLE is taken this edge but not finished, so upstream holds.
    assign stall = (fsmState != IDLE) || (ex_valid && memOp);

    mem_req_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_reqFsm (
        .clk     (clk),
        .rst     (rst),
        .start   (ex_valid && memOp),
        .isStore (MemWrite),
        .isLoad  (MemRead && !MemWrite),
        .addr    (ALURes),
        .wdata   (WriteData),
        .bus     (bus),
        .state   (fsmState),
        .loadOp  (loadOp),
        .xferDone(xferDone),
        .xferFail(xferFail),
        .memErr  (mem_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid       <= 1'b0;
            PCOut          <= '0;
            ALUResOut      <= '0;
            MemReadDataOut <= '0;
            MemReadOut     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (accept) begin
                PCOut          <= PC;
                ALUResOut      <= ALURes;
                MemReadDataOut <= '0;
                MemReadOut     <= 1'b0;
                wb_valid       <= !memOp;
            end else if (xferDone) begin
                wb_valid       <= 1'b1;
                MemReadOut     <= loadOp && !xferFail;
                MemReadDataOut <= (loadOp && !xferFail) ? bus.mem_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomised scoreboard bench for mem_access: a driver issues instructions and predicts the
// writeback stream, a memory responder answers the bus, and a monitor checks each wb_valid beat.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int TO = 4;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] alu;
        logic [31:0] data;
        logic        rd;
        logic        err;
        logic        isMem;
        int          cyc;
    } wbExp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        int          delay;
        int          firstCyc;
    } busExp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid;
    logic [PC_W-1:0]   PC;
    logic [DATA_W-1:0] ALURes;
    logic [DATA_W-1:0] WriteData;
    logic              MemRead;
    logic              MemWrite;
    logic              stall;
    logic              wb_valid;
    logic [PC_W-1:0]   PCOut;
    logic [DATA_W-1:0] ALUResOut;
    logic [DATA_W-1:0] MemReadDataOut;
    logic              MemReadOut;
    logic              mem_err;

    mem_access_if bus();

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .PC            (PC),
        .ALURes        (ALURes),
        .WriteData     (WriteData),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .stall         (stall),
        .bus           (bus),
        .wb_valid      (wb_valid),
        .PCOut         (PCOut),
        .ALUResOut     (ALUResOut),
        .MemReadDataOut(MemReadDataOut),
        .MemReadOut    (MemReadOut),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int nChecks = 0;
    int nFails  = 0;

    wbExp_t  sbQ[$];
    busExp_t busQ[$];
    int      doneCycQ[$];

    logic [31:0] refMem [logic [31:0]];
    logic [31:0] slvMem [logic [31:0]];

    function automatic logic [31:0] initVal(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_mem_req"}, bus.mem_req, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_PCOut"}, PCOut, 0);
        chk({tag, "_ALUResOut"}, ALUResOut, 0);
        chk({tag, "_MemReadDataOut"}, MemReadDataOut, 0);
        chk({tag, "_MemReadOut"}, MemReadOut, 0);
        chk({tag, "_mem_err"}, mem_err, 0);
        chk({tag, "_stall"}, stall, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one instruction; returns once the stage is ready for the next one.
    task automatic issue(input logic [15:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                         input logic rd, input logic wr, input int delay);
        wbExp_t  e;
        busExp_t b;
        logic    isMem;
        int      reqs;
        bit      seen;
        isMem     = rd | wr;
        ex_valid  = 1'b1;
        PC        = pc;
        ALURes    = alu;
        WriteData = wd;
        MemRead   = rd;
        MemWrite  = wr;
        e.pc    = pc;
        e.alu   = alu;
        e.err   = 1'b0;
        e.isMem = isMem;
        e.cyc   = cyc + 1;
        e.rd    = rd & !wr;
        e.data  = 32'h0;
        if (e.rd) e.data = refMem.exists(alu) ? refMem[alu] : initVal(alu);
        if (wr) refMem[alu] = wd;
        sbQ.push_back(e);
        if (isMem) begin
            b.addr     = alu;
            b.wdata    = wd;
            b.we       = wr;
            b.delay    = delay;
            b.firstCyc = cyc + 1;
            busQ.push_back(b);
        end
        @(posedge clk);
        #1;
        if (isMem) begin
            reqs = 0;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                chk("stall_busy", stall, 1);
                if (wb_valid) begin
                    seen = 1;
                    break;
                end
                if (bus.mem_req) reqs++;
                @(posedge clk);
                #1;
            end
            if (!seen) begin
                nChecks++;
                nFails++;
                $display("FAIL mem_op_bound: no wb_valid within 40 cycles, addr %0h", alu);
            end
            chk("req_cycles", reqs, delay);
            ex_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        ex_valid = 1'b0;
    endtask

    // Memory responder: acks after the per-transaction number of request cycles.
    bit      respEnable = 1;
    bit      forceAck   = 0;
    int      reqCnt     = 0;
    bit      ackPrev    = 0;
    bit      haveCur    = 0;
    busExp_t cur;

    always @(negedge clk) begin
        bus.mem_rdata = $urandom;
        if (!respEnable) begin
            bus.mem_ack = forceAck;
            reqCnt      = 0;
            ackPrev     = 0;
        end else begin
            bus.mem_ack = 1'b0;
            if (ackPrev) begin
                chk("req_drop_after_ack", bus.mem_req, 0);
                ackPrev = 0;
            end
            if (bus.mem_req) begin
                if (reqCnt == 0) begin
                    if (busQ.size() == 0) begin
                        nChecks++;
                        nFails++;
                        haveCur = 0;
                        $display("FAIL bus_unexpected: mem_req at addr %0h, nothing expected", bus.mem_addr);
                    end else begin
                        cur     = busQ.pop_front();
                        haveCur = 1;
                        chk("req_first_cycle", cyc, cur.firstCyc);
                    end
                end
                reqCnt++;
                chk("stall_on_req", stall, 1);
                if (haveCur) begin
                    chk("mem_addr", bus.mem_addr, cur.addr);
                    chk("mem_we", bus.mem_we, cur.we);
                    chk("mem_wdata", bus.mem_wdata, cur.wdata);
                end
                if (!haveCur || reqCnt >= cur.delay) begin
                    bus.mem_ack = 1'b1;
                    if (haveCur && cur.we) slvMem[cur.addr] = cur.wdata;
                    if (haveCur && !cur.we)
                        bus.mem_rdata = slvMem.exists(cur.addr) ? slvMem[cur.addr] : initVal(cur.addr);
                    doneCycQ.push_back(cyc + 1);
                    ackPrev = 1;
                    reqCnt  = 0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.mem_ack = 1'b1;
            end
        end
    end

    // Writeback monitor.
    wbExp_t monE;
    int     monCyc;

    always @(negedge clk) begin
        if (wb_valid) begin
            if (sbQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL wb_unexpected: wb_valid with PCOut %0h, nothing expected", PCOut);
            end else begin
                monE   = sbQ.pop_front();
                monCyc = monE.cyc;
                if (monE.isMem) monCyc = (doneCycQ.size() == 0) ? -1 : doneCycQ.pop_front();
                chk("wb_cycle", cyc, monCyc);
                chk("PCOut", PCOut, monE.pc);
                chk("ALUResOut", ALUResOut, monE.alu);
                chk("MemReadDataOut", MemReadDataOut, monE.data);
                chk("MemReadOut", MemReadOut, monE.rd);
                chk("mem_err_wb", mem_err, monE.err);
            end
        end else begin
            chk("mem_err_idle", mem_err, 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        ex_valid  = 1'b0;
        PC        = '0;
        ALURes    = '0;
        WriteData = '0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        idle(3);
        chkAllZero("reset");
        rst = 1'b0;

        issue(16'h0010, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 1);
        refMem[32'h100] = 32'hDEAD_BEEF;
        slvMem[32'h100] = 32'hDEAD_BEEF;
        issue(16'h0020, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 3);
        issue(16'h0024, 32'h0000_0104, 32'hCAFE_F00D, 1'b0, 1'b1, 1);
        issue(16'h0028, 32'h0000_0108, 32'h1111_2222, 1'b1, 1'b1, 2);
        issue(16'h002C, 32'h0000_0108, 32'h0, 1'b1, 1'b0, 2);

        // Reset during the second WAIT cycle; a late ack must not produce writeback.
        respEnable = 0;
        forceAck   = 0;
        ex_valid   = 1'b1;
        PC         = 16'h0030;
        ALURes     = 32'h0000_010C;
        WriteData  = 32'h0;
        MemRead    = 1'b1;
        MemWrite   = 1'b0;
        idle(2);
        chk("rst_wait_req", bus.mem_req, 1);
        rst      = 1'b1;
        ex_valid = 1'b0;
        idle(1);
        rst = 1'b0;
        chkAllZero("rst_mid_wait");
        forceAck = 1;
        repeat (2) begin
            idle(1);
            chk("late_ack_wb", wb_valid, 0);
            chk("late_ack_req", bus.mem_req, 0);
        end
        forceAck = 0;
        idle(1);
        chk("late_ack_wb_end", wb_valid, 0);
        respEnable = 1;
        issue(16'h0034, 32'h0000_5678, 32'h0, 1'b0, 1'b0, 1);

`ifdef MEM_TIMEOUT_EN
        begin : timeoutTest
            wbExp_t te;
            int     reqs;
            respEnable = 0;
            forceAck   = 0;
            te.pc    = 16'h0040;
            te.alu   = 32'h0000_0110;
            te.data  = 32'h0;
            te.rd    = 1'b0;
            te.err   = 1'b1;
            te.isMem = 1'b1;
            te.cyc   = 0;
            sbQ.push_back(te);
            doneCycQ.push_back(cyc + 1 + TO);
            ex_valid  = 1'b1;
            PC        = 16'h0040;
            ALURes    = 32'h0000_0110;
            WriteData = 32'h0;
            MemRead   = 1'b1;
            MemWrite  = 1'b0;
            idle(1);
            reqs = 0;
            for (int i = 0; i < 20; i++) begin
                if (wb_valid) break;
                if (bus.mem_req) reqs++;
                idle(1);
            end
            chk("timeout_req_cycles", reqs, TO);
            ex_valid = 1'b0;
            idle(1);
            respEnable = 1;
        end
`endif

        for (int n = 0; n < 80; n++) begin
            int          kind;
            logic        r;
            logic        w;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            r    = (kind inside {[4:6], 9});
            w    = (kind inside {[7:9]});
            a    = (r | w) ? (32'h200 + 32'($urandom_range(0, 7)) * 4) : 32'($urandom);
            issue(16'($urandom), a, 32'($urandom), r, w, $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(10);
        chk("sb_drained", sbQ.size(), 0);
        chk("bus_drained", busQ.size(), 0);
        chk("done_drained", doneCycQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Pipeline memory stage between execute and writeback. Takes the ALU result as a data address plus store data. Runs a request/acknowledge transaction with data memory for loads and stores, stalling the pipeline until the memory responds. Presents PC, ALU result, load data and the MemRead select to writeback one registered stage later.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles waiting for `mem_ack`. Used only with `MEM_TIMEOUT_EN`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset; **synchronous, active-high**.
- `ex_valid` in 1: execute stage presents a valid instruction.
- `PC` in 16: instruction PC.
- `ALURes` in 32: ALU result; it is the byte address for memory ops.
- `WriteData` in 32: store data.
- `MemRead` in 1: instruction is a load.
- `MemWrite` in 1: instruction is a store.
- `stall` out 1: upstream must hold its inputs and `ex_valid`.
- `mem_req` out 1: memory request.
- `mem_we` out 1: request is a write.
- `mem_addr` out 32: request address.
- `mem_wdata` out 32: request write data.
- `mem_rdata` in 32: read data; valid when `mem_ack` is high.
- `mem_ack` in 1: memory completes the request.
- `wb_valid` out 1: writeback outputs are valid this cycle.
- `PCOut` out 16: PC passed to writeback.
- `ALUResOut` out 32: ALU result passed to writeback.
- `MemReadDataOut` out 32: captured load data (0 for non-loads).
- `MemReadOut` out 1: writeback selects memory data.
- `mem_err` out 1: timeout pulse. Tied 0 without `MEM_TIMEOUT_EN`.

## Operation
- **States:** IDLE, WAIT, DONE.
- **IDLE, non-memory op** (`ex_valid` and neither `MemRead` nor `MemWrite`):
  - Register PC and ALURes to the outputs.
  - Next cycle `wb_valid`=1, `MemReadOut`=0, `MemReadDataOut`=0.
  - Stay in IDLE.
- **IDLE, memory op** (`ex_valid` with `MemRead` or `MemWrite`):
  - Latch PC, ALURes, WriteData and op type; go to WAIT.
  - In WAIT: `mem_req`=1, `mem_addr`=latched ALURes, `mem_wdata`=latched WriteData.
  - `mem_we`=1 for stores and 0 for loads.
- **MemRead and MemWrite both set:** treated as a store; `MemReadOut`=0.
- **WAIT:**
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are held stable until `mem_ack` is sampled high.
  - On ack: capture `mem_rdata` for a load (0 for a store) and go to DONE.
- **DONE:**
  - `wb_valid`=1 and `MemReadOut`=latched load flag.
  - Return to IDLE. The stage does not accept input in DONE.
- **stall:** high in WAIT and DONE. It is also high combinationally in IDLE when `ex_valid` and a memory op are present, since the op is accepted but not yet complete.
- **Outside a transaction:** `wb_valid` is 0 in all other cycles; writeback ignores the data outputs then.
- **`mem_ack` without request:** ignored when `mem_req` is 0.
- **Reset, including mid-WAIT:** next edge gives state IDLE. All outputs are 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `wb_valid`, `PCOut`, `ALUResOut`, `MemReadDataOut`, `MemReadOut`, `mem_err`, `stall`. An in-flight request is abandoned; a late ack is ignored.
- **Widths:** no arithmetic except the timeout counter, which is sized `$clog2(TIMEOUT_CYCLES+1)` and saturates.

## Timing
- **Non-memory op:** accepted at edge N; `wb_valid` is high during cycle N+1.
- **Memory op:**
  - Accepted at edge N; `mem_req` rises after edge N.
  - If `mem_ack` is sampled at edge N+k (k≥1), DONE occurs in cycle N+k+1 with `wb_valid` high.
  - Minimum load-to-writeback latency is 2 cycles.
- **Back-to-back non-memory ops:** one per cycle, no bubbles.
- **After a memory op:** at least one dead cycle (DONE) before the next accept.

## Configuration
- **`MEM_TIMEOUT_EN` defined:**
  - The counter clears on entering WAIT and increments each WAIT cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`, the request is dropped and the block goes to DONE.
  - `mem_err` pulses for one cycle with DONE.
  - `MemReadDataOut`=0 and `MemReadOut`=0.
- **Undefined:** WAIT holds indefinitely; `mem_err` is constant 0; no counter logic.

## Structure
- **Shared package:**
  - State enum `mem_state_t` {IDLE, WAIT, DONE}.
  - Width constants `PC_W`=16 and `DATA_W`=32, shared with the writeback stage.
- **Sub-module:** `mem_req_fsm` owns the state, request registers and optional timeout. The top level holds the writeback output registers and the stall logic.

## Test plan
- **Non-memory op:** PC=0x0010, ALURes=0x1234, no mem op → next cycle `wb_valid`=1, `PCOut`=0x0010, `ALUResOut`=0x1234, `MemReadOut`=0, no `mem_req`.
- **Load with delayed ack:** MemRead, ALURes=0x100; ack after 3 cycles with rdata=0xDEADBEEF. Require:
  - `mem_req` high exactly 3 cycles with `mem_addr`=0x100 and `mem_we`=0.
  - `stall` high throughout.
  - DONE: `MemReadDataOut`=0xDEADBEEF, `MemReadOut`=1.
- **Store:** MemWrite, WriteData=0xCAFEF00D, ack after 1 cycle → `mem_we`=1, `mem_wdata`=0xCAFEF00D. DONE: `MemReadOut`=0, `MemReadDataOut`=0.
- **Both flags set:** MemRead and MemWrite together → store on the bus (`mem_we`=1), `MemReadOut`=0.
- **Reset mid-WAIT:** `rst` pulsed in 2nd WAIT cycle → next cycle all outputs 0 and IDLE. A later `mem_ack` causes no `wb_valid`.
- **Timeout (`MEM_TIMEOUT_EN`):** `TIMEOUT_CYCLES`=4, no ack → `mem_req` high 4 cycles, then `mem_err`=1 and `wb_valid`=1 for one cycle, `MemReadOut`=0.
